zstr_src_gen: RTL

Parametrised, synthesizable zstr stream source.
- Entries are loaded through a synchronous put port into a circular queue, then presented on the z_vld/z_bus/z_rdy stream.
- Each entry carries a programmable pre-transfer idle delay.
- Adds loop (replay) mode, synchronous flush, sticky overflow detection and a transfer counter.
- Used in benches and on-chip pattern generators wherever a zstr producer is needed.

---
 rtl/zstr_pkg.sv | 4 +
 rtl/zstr_queue.sv | 52 +++++
 rtl/zstr_src_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/zstr_pkg.sv
// zstr_pkg: shared state type for the zstr stream source.
package zstr_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, VALID} zstr_src_state_t;
endpackage

// File: rtl/zstr_queue.sv
// zstr_queue: circular entry buffer for zstr_src_gen, any depth QL >= 1.
//   put/put_ent : append put_ent at the tail
//   pop         : drop the head
//   rot         : move the head to the tail (count unchanged)
//   head/second : first and second stored entries
//   cnt         : number of stored entries
module zstr_queue #(
    parameter int W  = 8,
    parameter int QL = 4,
    parameter int QW = (QL > 1) ? $clog2(QL) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         put,
    input  logic         pop,
    input  logic         rot,
    input  logic [W-1:0] put_ent,
    output logic [W-1:0] head,
    output logic [W-1:0] second,
    output logic [QW:0]  cnt
);
    logic [W-1:0]  mem [QL];
    logic [QW-1:0] rd;
    logic [QW-1:0] wr;

    // Explicit wrap so depths that are not powers of two work.
    function automatic logic [QW-1:0] inc(input logic [QW-1:0] p);
        return (p == QW'(QL - 1)) ? '0 : p + QW'(1);
    endfunction

    assign head   = mem[rd];
    assign second = mem[inc(rd)];

    always_ff @(posedge clk)
        if (put || rot) mem[wr] <= rot ? head : put_ent;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            rd  <= '0;
            wr  <= '0;
            cnt <= '0;
        end else begin
            if (pop || rot) rd <= inc(rd);
            if (put || rot) wr <= inc(wr);
            if (put != pop && !rot) cnt <= put ? cnt + (QW+1)'(1) : cnt - (QW+1)'(1);
        end
endmodule

// File: rtl/zstr_src_gen.sv
// zstr_src_gen: queued zstr stream source with per-entry idle delay and replay.
//   put_vld/put_bus/put_dly/put_rdy : entry load port
//   mode_loop : replay queued entries cyclically
//   clr       : synchronous flush
//   ovf       : sticky, put offered while put_rdy=0
//   q_cnt     : stored entries, trn_cnt : completed transfers
//   z_vld/z_bus/z_rdy : outgoing stream
module zstr_src_gen
    import zstr_pkg::*;
#(
    parameter int   BW = 1,
    parameter logic XZ = 1'bx,
    parameter int   QL = 4,
    parameter int   QW = (QL > 1) ? $clog2(QL) : 1,
    parameter int   DW = 4,
    parameter int   CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          mode_loop,
    input  logic          put_vld,
    input  logic [BW-1:0] put_bus,
    input  logic [DW-1:0] put_dly,
    output logic          put_rdy,
    output logic          ovf,
    output logic [QW:0]   q_cnt,
    output logic [CW-1:0] trn_cnt,
    output logic          z_vld,
    output logic [BW-1:0] z_bus,
    input  logic          z_rdy
);
    typedef struct packed {
        logic [DW-1:0] dly;
        logic [BW-1:0] bus;
    } zstr_src_ent_t;

    zstr_src_state_t st;
    zstr_src_ent_t   head, second, put_ent, ld_ent;
    logic [DW-1:0]   dcnt;
    logic            put, trn, ld;

    assign put_rdy = (q_cnt < (QW+1)'(QL)) && !mode_loop;
    assign put     = put_vld && put_rdy;
    assign trn     = z_vld && z_rdy;
    assign put_ent = '{dly: put_dly, bus: put_bus};

    // The entry following a transfer: the stored second entry, the head itself
    // when replaying a single entry, or one being put in the same cycle.
    assign ld_ent = (st != VALID) ? head :
                    (q_cnt > (QW+1)'(1)) ? second :
                    mode_loop ? head : put_ent;
    assign ld = (st == IDLE) ? (q_cnt != '0) :
                (st == VALID) && z_rdy && (q_cnt > (QW+1)'(1) || mode_loop || put);

    zstr_queue #(.W(DW + BW), .QL(QL), .QW(QW)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .put     (put),
        .pop     (trn && !mode_loop),
        .rot     (trn && mode_loop),
        .put_ent (put_ent),
        .head    (head),
        .second  (second),
        .cnt     (q_cnt)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st      <= IDLE;
            dcnt    <= '0;
            z_vld   <= 1'b0;
            z_bus   <= {BW{XZ}};
            ovf     <= 1'b0;
            trn_cnt <= '0;
        end else if (clr) begin
            st      <= IDLE;
            dcnt    <= '0;
            z_vld   <= 1'b0;
            z_bus   <= {BW{XZ}};
            ovf     <= 1'b0;
            trn_cnt <= '0;
        end else begin
            if (put_vld && !put_rdy) ovf <= 1'b1;
            if (trn) trn_cnt <= trn_cnt + CW'(1);
            if (ld) begin
                dcnt  <= ld_ent.dly;
                st    <= (ld_ent.dly == '0) ? VALID : WAIT;
                z_vld <= ld_ent.dly == '0;
                z_bus <= (ld_ent.dly == '0) ? ld_ent.bus : {BW{XZ}};
            end else if (st == WAIT) begin
                dcnt <= dcnt - DW'(1);
                if (dcnt == DW'(1)) begin
                    st    <= VALID;
                    z_vld <= 1'b1;
                    z_bus <= head.bus;
                end
            end else if (trn) begin
                st    <= IDLE;
                z_vld <= 1'b0;
                z_bus <= {BW{XZ}};
            end
        end
endmodule
